// File: rtl/imu_pkg.sv
// Shared types and helpers for the IMU burst sampler.
package imu_pkg;

  // Frame-sequencing states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RECV    = 3'd2,
    PUBLISH = 3'd3,
    ABORT   = 3'd4
  } state_t;

  // One big-endian sensor channel.
  typedef logic [15:0] sample_t;

  // Largest supported channel count; the byte index is sized for 2*MAX_CH.
  localparam int MAX_CH = 16;
  localparam int IDX_W  = 6;

  // Saturating 8-bit increment used by the status counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/imu_frame_buf.sv
// Shadow buffer filled byte-by-byte during a burst, plus the published
// frame register with its valid/ready handshake and overrun counter.
module imu_frame_buf
  import imu_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_byte,
  input  logic                  publish,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [16*NUM_CH-1:0]  frame_data,
  output logic [7:0]            overrun_cnt
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      sample_t shadow_reg;
      sample_t out_reg;

      // Capture the high byte on the even index and the low byte on the odd one.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          shadow_reg <= '0;
        end else if (wr_en && (wr_idx[IDX_W-1:1] == (IDX_W-1)'(gi))) begin
          if (wr_idx[0]) begin
            shadow_reg[7:0] <= wr_byte;
          end else begin
            shadow_reg[15:8] <= wr_byte;
          end
        end
      end

      // Copy the whole shadow into the visible frame in a single cycle.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_reg <= '0;
        end else if (publish) begin
          out_reg <= shadow_reg;
        end
      end

      assign frame_data[16*gi +: 16] = out_reg;
    end
  endgenerate

  // Valid/ready handshake; a publish over an unaccepted frame counts as an overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      overrun_cnt <= '0;
    end else if (publish) begin
      frame_valid <= 1'b1;
      if (frame_valid && !frame_ready) begin
        overrun_cnt <= sat_inc(overrun_cnt);
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imu_burst_sampler.sv
// Periodically burst-reads NUM_CH big-endian 16-bit registers through the
// byte-level I2C master and publishes each complete frame coherently.
module imu_burst_sampler
  import imu_pkg::*;
#(
  parameter int         NUM_CH     = 6,
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter logic [7:0] START_REG  = 8'h3B,
  parameter int         SAMPLE_DIV = 100000,
  parameter int         TIMEOUT    = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  rd_req,
  output logic [6:0]            rd_dev,
  output logic [7:0]            rd_reg,
  output logic [7:0]            rd_len,
  input  logic                  rd_byte_vld,
  input  logic [7:0]            rd_byte,
  input  logic                  rd_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [16*NUM_CH-1:0]  frame_data,
  output logic [7:0]            overrun_cnt,
  output logic [7:0]            err_cnt
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state_reg;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [IDX_W-1:0]   byte_idx_reg;
  logic               tick;
  logic               last_byte;
  logic               byte_take;
  logic               tmo_hit;

  assign tick      = (tick_cnt_reg == TICK_W'(SAMPLE_DIV - 1));
  assign last_byte = (byte_idx_reg == IDX_W'(2 * NUM_CH - 1));
  assign tmo_hit   = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
  // A byte is only accepted while receiving, and an error in the same cycle discards it.
  assign byte_take = (state_reg == RECV) && rd_byte_vld && !rd_err;

  // Request fields are presented only alongside the request pulse.
  assign rd_req = (state_reg == REQ);
  assign rd_dev = rd_req ? DEV_ADDR : 7'd0;
  assign rd_reg = rd_req ? START_REG : 8'd0;
  assign rd_len = rd_req ? 8'(2 * NUM_CH) : 8'd0;

  // Free-running sample period counter, parked at zero while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (!enable || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  // Frame sequencer with per-byte index and inter-byte timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tmo_cnt_reg  <= '0;
      byte_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Ticks seen in any other state are simply dropped.
          if (enable && tick) begin
            state_reg <= REQ;
          end
        end
        REQ: begin
          state_reg    <= RECV;
          tmo_cnt_reg  <= '0;
          byte_idx_reg <= '0;
        end
        RECV: begin
          if (rd_err) begin
            state_reg <= ABORT;
          end else if (rd_byte_vld) begin
            tmo_cnt_reg <= '0;
            if (last_byte) begin
              state_reg    <= PUBLISH;
              byte_idx_reg <= '0;
            end else begin
              byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            end
          end else if (tmo_hit) begin
            state_reg <= ABORT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        PUBLISH: state_reg <= IDLE;
        ABORT:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Count aborted frames, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (state_reg == ABORT) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  imu_frame_buf #(
    .NUM_CH (NUM_CH)
  ) u_frame_buf (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (byte_take),
    .wr_idx      (byte_idx_reg),
    .wr_byte     (rd_byte),
    .publish     (state_reg == PUBLISH),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .overrun_cnt (overrun_cnt)
  );

endmodule

// File: tb/tb_imu_burst_sampler.sv
// Directed bench for imu_burst_sampler with NUM_CH=3, SAMPLE_DIV=20, TIMEOUT=8.
module tb_imu_burst_sampler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rd_req;
  logic [6:0]  rd_dev;
  logic [7:0]  rd_reg;
  logic [7:0]  rd_len;
  logic        rd_byte_vld = 1'b0;
  logic [7:0]  rd_byte = 8'h00;
  logic        rd_err = 1'b0;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [47:0] frame_data;
  logic [7:0]  overrun_cnt;
  logic [7:0]  err_cnt;

  imu_burst_sampler #(
    .NUM_CH     (3),
    .DEV_ADDR   (7'h68),
    .START_REG  (8'h3B),
    .SAMPLE_DIV (20),
    .TIMEOUT    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rd_req      (rd_req),
    .rd_dev      (rd_dev),
    .rd_reg      (rd_reg),
    .rd_len      (rd_len),
    .rd_byte_vld (rd_byte_vld),
    .rd_byte     (rd_byte),
    .rd_err      (rd_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .overrun_cnt (overrun_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cyc = 0;

  typedef struct {
    logic [47:0] bytes;   // byte 0 in [47:40]
    logic [47:0] exp;     // channel k in [16k+15:16k]
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rd_req) begin
        ok = 1'b1;
        req_cyc = cyc;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: rd_req=0 after 100 cycles, expected 1");
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rd_byte_vld = 1'b1;
    rd_byte     = b;
    step();
    rd_byte_vld = 1'b0;
  endtask

  // Waits for a request, optionally drops enable mid-frame, then feeds all six bytes.
  // Returns #1 after the edge that accepted the last byte.
  task automatic frame_bytes(input logic [47:0] bytes, input bit drop_en, output bit ok);
    wait_req(ok);
    if (!ok) return;
    chk("rd_dev", 64'(rd_dev), 64'h68);
    chk("rd_reg", 64'(rd_reg), 64'h3B);
    chk("rd_len", 64'(rd_len), 64'd6);
    if (drop_en) enable = 1'b0;
    step();
    for (int j = 0; j < 6; j++) begin
      send_byte(bytes[47-8*j -: 8]);
    end
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int prev_req;
    int pulses;

    vecs[0] = '{bytes: 48'h0010_FFF0_8000, exp: 48'h8000_FFF0_0010};
    vecs[1] = '{bytes: 48'h1234_5678_9ABC, exp: 48'h9ABC_5678_1234};
    vecs[2] = '{bytes: 48'hFFFF_0000_A55A, exp: 48'hA55A_0000_FFFF};

    // Reset state
    repeat (3) step();
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data", 64'(frame_data), 64'd0);
    chk("rst_req", 64'(rd_req), 64'd0);
    chk("rst_ovr", 64'(overrun_cnt), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Table: byte assembly, 2-cycle latency, request period, accept
    prev_req = 0;
    for (int i = 0; i < 3; i++) begin
      frame_bytes(vecs[i].bytes, 1'b0, ok);
      if (i > 0) chk("req_period", 64'(req_cyc - prev_req), 64'd20);
      prev_req = req_cyc;
      chk("lat_not_yet", 64'(frame_valid), 64'd0);
      step();
      chk("lat_valid", 64'(frame_valid), 64'd1);
      chk("vec_data", 64'(frame_data), 64'(vecs[i].exp));
      accept();
      chk("valid_drop", 64'(frame_valid), 64'd0);
    end

    // enable low: no further requests
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rd_req) pulses++;
    end
    chk("no_req_disabled", 64'(pulses), 64'd0);
    enable = 1'b1;

    // Overrun: three unaccepted frames (first with enable dropped mid-frame)
    frame_bytes(48'h0102_0304_0506, 1'b1, ok);
    step();
    chk("ovr1_valid", 64'(frame_valid), 64'd1);
    chk("ovr1_data", 64'(frame_data), 64'h0506_0304_0102);
    chk("ovr1_cnt", 64'(overrun_cnt), 64'd0);
    enable = 1'b1;
    frame_bytes(48'h1122_3344_5566, 1'b0, ok);
    step();
    chk("ovr2_data", 64'(frame_data), 64'h5566_3344_1122);
    chk("ovr2_cnt", 64'(overrun_cnt), 64'd1);
    frame_bytes(48'hDEAD_BEEF_CAFE, 1'b0, ok);
    step();
    chk("ovr3_data", 64'(frame_data), 64'hCAFE_BEEF_DEAD);
    chk("ovr3_cnt", 64'(overrun_cnt), 64'd2);

    // Accept coinciding with publish: no overrun, valid stays with new data
    frame_bytes(vecs[0].bytes, 1'b0, ok);
    chk("hold_data", 64'(frame_data), 64'hCAFE_BEEF_DEAD);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("coinc_valid", 64'(frame_valid), 64'd1);
    chk("coinc_data", 64'(frame_data), 64'(vecs[0].exp));
    chk("coinc_cnt", 64'(overrun_cnt), 64'd2);
    accept();
    chk("coinc_drop", 64'(frame_valid), 64'd0);

    // rd_err after three bytes, together with a strobe that must be discarded
    wait_req(ok);
    step();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    rd_err = 1'b1;
    rd_byte_vld = 1'b1;
    rd_byte = 8'hFF;
    step();
    rd_err = 1'b0;
    rd_byte_vld = 1'b0;
    step();
    chk("err_cnt1", 64'(err_cnt), 64'd1);
    chk("err_valid", 64'(frame_valid), 64'd0);
    chk("err_data", 64'(frame_data), 64'(vecs[0].exp));
    frame_bytes(vecs[1].bytes, 1'b0, ok);
    step();
    chk("after_err_data", 64'(frame_data), 64'(vecs[1].exp));
    accept();

    // Timeout: 8 silent cycles in RECV, abort on the 8th edge, count on the 9th
    wait_req(ok);
    step();
    repeat (8) step();
    chk("tmo_not_yet", 64'(err_cnt), 64'd1);
    step();
    chk("tmo_err_cnt", 64'(err_cnt), 64'd2);
    send_byte(8'hAA);
    step();
    chk("late_valid", 64'(frame_valid), 64'd0);
    frame_bytes(vecs[2].bytes, 1'b0, ok);
    step();
    chk("after_tmo_data", 64'(frame_data), 64'(vecs[2].exp));

    // Reset during RECV with an unconsumed frame pending
    wait_req(ok);
    step();
    send_byte(8'h99);
    send_byte(8'h88);
    rd_byte_vld = 1'b1;
    rd_byte = 8'h77;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(frame_valid), 64'd0);
    chk("mid_rst_data", 64'(frame_data), 64'd0);
    chk("mid_rst_ovr", 64'(overrun_cnt), 64'd0);
    chk("mid_rst_err", 64'(err_cnt), 64'd0);
    chk("mid_rst_req", 64'({rd_req, rd_dev, rd_reg, rd_len}), 64'd0);
    step();
    step();
    reset = 1'b0;
    rd_byte_vld = 1'b0;
    frame_bytes(vecs[1].bytes, 1'b0, ok);
    step();
    chk("post_rst_valid", 64'(frame_valid), 64'd1);
    chk("post_rst_data", 64'(frame_data), 64'(vecs[1].exp));
    chk("post_rst_cnts", 64'({overrun_cnt, err_cnt}), 64'd0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
